// File: rtl/mixer_nch_if.sv
// Bundles the mixer's sound-source inputs and mix/DAC outputs. The master drives the
// sources; the slave is the mixer. Parameters must match those of the mixer instance.
interface mixer_nch_if #(
  parameter int CHANNELS = 4,
  parameter int W        = 8,
  parameter int DAC_W    = 10
);
  logic [CHANNELS*W-1:0] ch_l;
  logic [CHANNELS*W-1:0] ch_r;
  logic [CHANNELS*4-1:0] gain_l;
  logic [CHANNELS*4-1:0] gain_r;
  logic                  beeper;
  logic                  tape_out;
  logic                  tape_in;
  logic [DAC_W-1:0]      mix_l;
  logic [DAC_W-1:0]      mix_r;
  logic                  sample_tick;
  logic                  dac_l;
  logic                  dac_r;

  modport master (
    output ch_l, ch_r, gain_l, gain_r, beeper, tape_out, tape_in,
    input  mix_l, mix_r, sample_tick, dac_l, dac_r
  );

  modport slave (
    input  ch_l, ch_r, gain_l, gain_r, beeper, tape_out, tape_in,
    output mix_l, mix_r, sample_tick, dac_l, dac_r
  );
endinterface

// File: rtl/mixer_nch.sv
// Time-multiplexed N-channel stereo PCM/1-bit mixer with delta-sigma DAC outputs.
// Define MIXER_SECOND_ORDER_EN for a second-order modulator; first-order otherwise.
module mixer_nch #(
  parameter int CHANNELS    = 4,
  parameter int W           = 8,
  parameter int DAC_W       = 10,
  parameter int SHIFT       = 3,
  parameter int SAMPLE_DIV  = 64,
  parameter int BEEPER_LVL  = 1024,
  parameter int TAPEOUT_LVL = 256,
  parameter int TAPEIN_LVL  = 128
) (
  input  logic        clk28,
  input  logic        rst_n,
  mixer_nch_if.slave  bus
);

  localparam int AW      = W + 4 + $clog2(CHANNELS + 1) + 2;
  localparam int SW      = (AW > DAC_W) ? AW : DAC_W;
  localparam int CW      = $clog2(SAMPLE_DIV);
  localparam int KW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int MAX_MIX = (1 << DAC_W) - 1;

  generate
    if (SAMPLE_DIV < CHANNELS + 3) begin : g_bad_div
      $error("mixer_nch: SAMPLE_DIV must be >= CHANNELS+3");
    end
    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
      $error("mixer_nch: CHANNELS must be in 1..8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCUM, ONEBIT, LOAD} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [KW-1:0]         k_q, k_d;
  logic [AW-1:0]         acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [CHANNELS*W-1:0] snap_ch_l_q, snap_ch_l_d, snap_ch_r_q, snap_ch_r_d;
  logic [CHANNELS*4-1:0] snap_g_l_q, snap_g_l_d, snap_g_r_q, snap_g_r_d;
  logic [2:0]            snap_lvl_q, snap_lvl_d;   // {beeper, tape_out, tape_in}
  logic [DAC_W-1:0]      mix_l_q, mix_l_d, mix_r_q, mix_r_d;
  logic [AW-1:0]         lvl_sum;

  function automatic logic [W+3:0] chan_prod(input logic [CHANNELS*W-1:0] s,
                                             input logic [CHANNELS*4-1:0] g,
                                             input logic [KW-1:0]         k);
    logic [W-1:0] x;
    logic [3:0]   y;
    x = s[int'(k)*W +: W];
    y = g[int'(k)*4 +: 4];
    return {4'b0, x} * {{W{1'b0}}, y};
  endfunction

  function automatic logic [DAC_W-1:0] saturate(input logic [AW-1:0] a);
    logic [SW-1:0] sh;
    sh = SW'(a) >> SHIFT;
    if (sh > SW'(MAX_MIX)) return DAC_W'(MAX_MIX);
    return sh[DAC_W-1:0];
  endfunction

  always_comb begin
    lvl_sum = (snap_lvl_q[2] ? AW'(BEEPER_LVL)  : '0)
            + (snap_lvl_q[1] ? AW'(TAPEOUT_LVL) : '0)
            + (snap_lvl_q[0] ? AW'(TAPEIN_LVL)  : '0);
  end

  // NOTE: every always_comb output gets a hold/default value first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CW'(SAMPLE_DIV - 1)) ? '0 : cnt_q + 1'b1;
    k_d         = k_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    snap_ch_l_d = snap_ch_l_q;
    snap_ch_r_d = snap_ch_r_q;
    snap_g_l_d  = snap_g_l_q;
    snap_g_r_d  = snap_g_r_q;
    snap_lvl_d  = snap_lvl_q;
    mix_l_d     = mix_l_q;
    mix_r_d     = mix_r_q;

    unique case (state_q)
      IDLE: begin
        if (cnt_q == '0) begin
          snap_ch_l_d = bus.ch_l;
          snap_ch_r_d = bus.ch_r;
          snap_g_l_d  = bus.gain_l;
          snap_g_r_d  = bus.gain_r;
          snap_lvl_d  = {bus.beeper, bus.tape_out, bus.tape_in};
          acc_l_d     = '0;
          acc_r_d     = '0;
          k_d         = '0;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        acc_l_d = acc_l_q + AW'(chan_prod(snap_ch_l_q, snap_g_l_q, k_q));
        acc_r_d = acc_r_q + AW'(chan_prod(snap_ch_r_q, snap_g_r_q, k_q));
        if (k_q == KW'(CHANNELS - 1)) state_d = ONEBIT;
        else                          k_d     = k_q + 1'b1;
      end
      ONEBIT: begin
        acc_l_d = acc_l_q + lvl_sum;
        acc_r_d = acc_r_q + lvl_sum;
        state_d = LOAD;
      end
      LOAD: begin
        mix_l_d = saturate(acc_l_q);
        mix_r_d = saturate(acc_r_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // sample the pre-edge values regardless of statement order.
  // NOTE: the snapshot registers are reset too; they are few flops, and a
  // defined value keeps the first frame after reset deterministic.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      snap_ch_l_q <= '0;
      snap_ch_r_q <= '0;
      snap_g_l_q  <= '0;
      snap_g_r_q  <= '0;
      snap_lvl_q  <= '0;
      mix_l_q     <= '0;
      mix_r_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      snap_ch_l_q <= snap_ch_l_d;
      snap_ch_r_q <= snap_ch_r_d;
      snap_g_l_q  <= snap_g_l_d;
      snap_g_r_q  <= snap_g_r_d;
      snap_lvl_q  <= snap_lvl_d;
      mix_l_q     <= mix_l_d;
      mix_r_q     <= mix_r_d;
    end
  end

  assign bus.mix_l       = mix_l_q;
  assign bus.mix_r       = mix_r_q;
  assign bus.sample_tick = (state_q == LOAD);

`ifdef MIXER_SECOND_ORDER_EN
  localparam int EW = DAC_W + 4;

  logic signed [EW-1:0] e1_l_q, e1_l_d, e2_l_q, e2_l_d, fb_l;
  logic signed [EW-1:0] e1_r_q, e1_r_d, e2_r_q, e2_r_d, fb_r;
  logic                 dac_l_q, dac_l_d, dac_r_q, dac_r_d;

  // Strict e2 > 0 keeps an all-zero state (and mix=0) emitting constant 0.
  always_comb begin
    fb_l    = dac_l_q ? EW'(1 << DAC_W) : '0;
    fb_r    = dac_r_q ? EW'(1 << DAC_W) : '0;
    e1_l_d  = e1_l_q + $signed({4'b0, mix_l_q}) - fb_l;
    e1_r_d  = e1_r_q + $signed({4'b0, mix_r_q}) - fb_r;
    e2_l_d  = e2_l_q + e1_l_d - fb_l;
    e2_r_d  = e2_r_q + e1_r_d - fb_r;
    dac_l_d = (e2_l_d > 0);
    dac_r_d = (e2_r_d > 0);
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      e1_l_q  <= '0;
      e2_l_q  <= '0;
      e1_r_q  <= '0;
      e2_r_q  <= '0;
      dac_l_q <= 1'b0;
      dac_r_q <= 1'b0;
    end else begin
      e1_l_q  <= e1_l_d;
      e2_l_q  <= e2_l_d;
      e1_r_q  <= e1_r_d;
      e2_r_q  <= e2_r_d;
      dac_l_q <= dac_l_d;
      dac_r_q <= dac_r_d;
    end
  end

  assign bus.dac_l = dac_l_q;
  assign bus.dac_r = dac_r_q;
`else
  logic [DAC_W:0] s_l_q, s_l_d, s_r_q, s_r_d;

  // The carry out of the residue add is the bitstream; it fires exactly mix
  // times per 2^DAC_W clocks for a constant mix.
  always_comb begin
    s_l_d = {1'b0, s_l_q[DAC_W-1:0]} + {1'b0, mix_l_q};
    s_r_d = {1'b0, s_r_q[DAC_W-1:0]} + {1'b0, mix_r_q};
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      s_l_q <= '0;
      s_r_q <= '0;
    end else begin
      s_l_q <= s_l_d;
      s_r_q <= s_r_d;
    end
  end

  assign bus.dac_l = s_l_q[DAC_W];
  assign bus.dac_r = s_r_q[DAC_W];
`endif

endmodule

// File: tb/tb_mixer_nch.sv
// Directed self-checking bench for mixer_nch (CHANNELS=4, W=8, DAC_W=10, SAMPLE_DIV=64).
// Expected mixes are hand-computed: (sum of sample*gain + levels) >> 3, capped at 1023.
module tb_mixer_nch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mixer_nch_if #(.CHANNELS(4), .W(8), .DAC_W(10)) bus ();

  mixer_nch #(
    .CHANNELS(4), .W(8), .DAC_W(10), .SHIFT(3), .SAMPLE_DIV(64),
    .BEEPER_LVL(1024), .TAPEOUT_LVL(256), .TAPEIN_LVL(128)
  ) dut (
    .clk28 (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic clear_inputs();
    bus.ch_l = '0; bus.ch_r = '0; bus.gain_l = '0; bus.gain_r = '0;
    bus.beeper = 1'b0; bus.tape_out = 1'b0; bus.tape_in = 1'b0;
  endtask

  task automatic wait_tick(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.sample_tick === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tick_timeout: no sample_tick within %0d clocks", budget);
    end
  endtask

  // Two ticks guarantee a frame whose snapshot saw the current inputs; then step past LOAD.
  task automatic settle_mix();
    wait_tick(200);
    wait_tick(200);
    @(negedge clk);
  endtask

  task automatic count_ones(input int n, output int ones_l, output int ones_r);
    ones_l = 0;
    ones_r = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ones_l += int'(bus.dac_l);
      ones_r += int'(bus.dac_r);
    end
  endtask

  task automatic check_mix(input string name, input int exp_l, input int exp_r);
    checks++;
    if (int'(bus.mix_l) !== exp_l) begin
      errors++;
      $display("FAIL %s_l: got %0d expected %0d", name, bus.mix_l, exp_l);
    end
    checks++;
    if (int'(bus.mix_r) !== exp_r) begin
      errors++;
      $display("FAIL %s_r: got %0d expected %0d", name, bus.mix_r, exp_r);
    end
  endtask

  task automatic check_density(input string name, input int got, input int exp_ones);
    int tol;
`ifdef MIXER_SECOND_ORDER_EN
    tol = (exp_ones == 0) ? 0 : 8;
`else
    tol = 0;
`endif
    checks++;
    if (got < exp_ones - tol || got > exp_ones + tol) begin
      errors++;
      $display("FAIL %s: got %0d ones expected %0d (+/-%0d)", name, got, exp_ones, tol);
    end
  endtask

  task automatic test_reset();
    int first_tick, second_tick, ones_l, ones_r;
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.mix_l, bus.mix_r, bus.sample_tick, bus.dac_l, bus.dac_r} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got mix_l=%0d mix_r=%0d tick=%b dac=%b%b expected all 0",
               bus.mix_l, bus.mix_r, bus.sample_tick, bus.dac_l, bus.dac_r);
    end
    rst_n = 1'b1;
    first_tick = -1;
    second_tick = -1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (bus.sample_tick === 1'b1) begin
        if (first_tick < 0) first_tick = n;
        else if (second_tick < 0) second_tick = n;
      end
    end
    checks++;
    if (first_tick !== 6) begin
      errors++;
      $display("FAIL first_tick: got clock %0d expected 6", first_tick);
    end
    checks++;
    if (second_tick !== 70) begin
      errors++;
      $display("FAIL tick_period: got clock %0d expected 70", second_tick);
    end
    check_mix("zero_mix", 0, 0);
    count_ones(1024, ones_l, ones_r);
    check_density("zero_dac_l", ones_l, 0);
    check_density("zero_dac_r", ones_r, 0);
  endtask

  task automatic test_single_channel();
    int ones_l, ones_r;
    rst_n = 1'b0;
    clear_inputs();
    bus.ch_l[7:0]   = 8'd128;
    bus.gain_l[3:0] = 4'd8;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_tick(20);
    @(negedge clk);
    check_mix("single", 128, 0);
    repeat (2) @(negedge clk);
    count_ones(1024, ones_l, ones_r);
    check_density("single_dac_l", ones_l, 128);
    check_density("single_dac_r", ones_r, 0);
  endtask

  task automatic test_saturate();
    int ones_l, ones_r;
    bus.ch_l = '1; bus.ch_r = '1; bus.gain_l = '1; bus.gain_r = '1;
    bus.beeper = 1'b1;
    settle_mix();
    check_mix("saturate", 1023, 1023);
    repeat (2) @(negedge clk);
    count_ones(1024, ones_l, ones_r);
    check_density("saturate_dac_l", ones_l, 1023);
    check_density("saturate_dac_r", ones_r, 1023);
  endtask

  task automatic test_levels();
    logic [2:0] lvl [4] = '{3'b100, 3'b001, 3'b111, 3'b010};
    int         exp [4] = '{128, 16, 176, 32};
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      {bus.beeper, bus.tape_out, bus.tape_in} = lvl[i];
      settle_mix();
      check_mix($sformatf("levels_%03b", lvl[i]), exp[i], exp[i]);
    end
  endtask

  task automatic test_snapshot();
    clear_inputs();
    bus.ch_l[23:16]  = 8'd100;
    bus.gain_l[11:8] = 4'd4;
    settle_mix();
    check_mix("snap_base", 50, 0);
    // From clock 7 of a frame, 60 clocks lands mid-ACCUM of the next frame.
    repeat (60) @(negedge clk);
    bus.ch_l[23:16] = 8'd200;
    wait_tick(20);
    @(negedge clk);
    check_mix("snap_hold", 50, 0);
    wait_tick(100);
    @(negedge clk);
    check_mix("snap_next", 100, 0);
  endtask

  task automatic test_reset_mid_frame();
    int tick_at;
    clear_inputs();
    bus.ch_l[7:0]   = 8'd128;
    bus.gain_l[3:0] = 4'd8;
    bus.ch_r[15:8]  = 8'd64;
    bus.gain_r[7:4] = 4'd2;
    settle_mix();
    check_mix("pre_abort", 128, 16);
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mix_l, bus.mix_r, bus.sample_tick, bus.dac_l, bus.dac_r} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got mix_l=%0d mix_r=%0d tick=%b dac=%b%b expected all 0",
               bus.mix_l, bus.mix_r, bus.sample_tick, bus.dac_l, bus.dac_r);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick_at = -1;
    for (int n = 1; n <= 20 && tick_at < 0; n++) begin
      @(negedge clk);
      if (bus.sample_tick === 1'b1) tick_at = n;
    end
    checks++;
    if (tick_at !== 6) begin
      errors++;
      $display("FAIL abort_first_tick: got clock %0d expected 6", tick_at);
    end
    @(negedge clk);
    check_mix("post_abort", 128, 16);
  endtask

  task automatic test_half_scale();
    int ones_l, ones_r;
    clear_inputs();
    bus.ch_l   = {4{8'd128}};
    bus.gain_l = {4{4'd8}};
    settle_mix();
    check_mix("half", 512, 0);
    repeat (64) @(negedge clk);
    count_ones(1024, ones_l, ones_r);
`ifdef MIXER_SECOND_ORDER_EN
    checks++;
    if (ones_l < 508 || ones_l > 516) begin
      errors++;
      $display("FAIL half_dac_l: got %0d ones expected 512 +/- 4", ones_l);
    end
`else
    check_density("half_dac_l", ones_l, 512);
`endif
    check_density("half_dac_r", ones_r, 0);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_channel();
    test_saturate();
    test_levels();
    test_snapshot();
    test_reset_mid_frame();
    test_half_scale();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
